// File: rtl/caxi4interconnect_slot_allocator_pkg.sv
// Shared constants and elaboration helpers for the transaction slot allocator.
package caxi4interconnect_slot_allocator_pkg;

  localparam int unsigned DEFAULT_NUM_SLOTS = 4;
  localparam int unsigned DEFAULT_IDX_W     = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/caxi4interconnect_slot_allocator_if.sv
// Allocation/release handshake bundle between the slot allocator and its consumer.
interface caxi4interconnect_slot_allocator_if
  import caxi4interconnect_slot_allocator_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int unsigned IDX_W     = DEFAULT_IDX_W
) ();

  logic                 allocValid;
  logic                 allocReady;
  logic [NUM_SLOTS-1:0] allocSlotOH;
  logic [IDX_W-1:0]     allocSlotIdx;
  logic                 relValid;
  logic [IDX_W-1:0]     relSlotIdx;
  logic [IDX_W:0]       busyCount;
  logic                 full;
  logic                 relErr;

  modport master (
    output allocValid, allocSlotOH, allocSlotIdx, busyCount, full, relErr,
    input  allocReady, relValid, relSlotIdx
  );

  modport slave (
    input  allocValid, allocSlotOH, allocSlotIdx, busyCount, full, relErr,
    output allocReady, relValid, relSlotIdx
  );

endinterface

// File: rtl/caxi4interconnect_slot_allocator_bitscan0.sv
// Finds the lowest-order zero bit of a vector and returns it one-hot.
module caxi4interconnect_BitScan0 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             found_o,
  output logic [WIDTH-1:0] oneHot_o
);

  logic [WIDTH-1:0] inv;

  assign inv      = ~vec_i;
  // Two's-complement trick isolates the lowest set bit of the inverted vector.
  assign oneHot_o = inv & (~inv + WIDTH'(1));
  assign found_o  = |inv;

endmodule

// File: rtl/caxi4interconnect_slot_allocator.sv
// Hands out free transaction slots one at a time and reclaims them on release.
module caxi4interconnect_slot_allocator
  import caxi4interconnect_slot_allocator_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int unsigned IDX_W     = clog2(NUM_SLOTS)
) (
  input  logic ACLK,
  input  logic ARESET,
  caxi4interconnect_slot_allocator_if.master bus
);

  logic [NUM_SLOTS-1:0] busyMaskQ, busyMaskD;
  logic                 allocValidQ, allocValidD;
  logic [NUM_SLOTS-1:0] allocSlotOHQ, allocSlotOHD;
  logic [IDX_W-1:0]     allocSlotIdxQ, allocSlotIdxD;
  logic [IDX_W:0]       busyCountQ, busyCountD;
  logic                 fullQ, fullD;
  logic                 relErrQ, relErrD;

  logic [NUM_SLOTS-1:0] relMask;
  logic [NUM_SLOTS-1:0] nextBusy;
  logic [NUM_SLOTS-1:0] scanOH;
  logic [IDX_W-1:0]     scanIdx;
  logic                 scanFound;
  logic                 relLegal;
  logic                 handshake;

  // Out-of-range indices decode to an all-zero mask and therefore count as illegal.
  always_comb begin
    relMask = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      relMask[i] = (bus.relSlotIdx == IDX_W'(i));
    end
  end

  // The offered candidate is reserved in busyMask but may not be released.
  assign relLegal  = bus.relValid & (|(relMask & busyMaskQ & ~allocSlotOHQ));
  assign handshake = allocValidQ & bus.allocReady;
  assign nextBusy  = relLegal ? (busyMaskQ & ~relMask) : busyMaskQ;

  caxi4interconnect_BitScan0 #(
    .WIDTH (NUM_SLOTS)
  ) u_scan (
    .vec_i    (nextBusy),
    .found_o  (scanFound),
    .oneHot_o (scanOH)
  );

  always_comb begin
    scanIdx = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (scanOH[i]) scanIdx = scanIdx | IDX_W'(i);
    end
  end

  always_comb begin
    busyMaskD     = nextBusy;
    allocValidD   = allocValidQ;
    allocSlotOHD  = allocSlotOHQ;
    allocSlotIdxD = allocSlotIdxQ;
    if (!allocValidQ || handshake) begin
      if (scanFound) begin
        allocValidD   = 1'b1;
        allocSlotOHD  = scanOH;
        allocSlotIdxD = scanIdx;
        busyMaskD     = nextBusy | scanOH;
      end else begin
        allocValidD   = 1'b0;
        allocSlotOHD  = '0;
        allocSlotIdxD = '0;
      end
    end
    // A legal release implies a slot is outstanding, so this cannot underflow.
    busyCountD = busyCountQ + (IDX_W+1)'(handshake) - (IDX_W+1)'(relLegal);
    fullD      = (busyCountD == (IDX_W+1)'(NUM_SLOTS));
    relErrD    = relErrQ | (bus.relValid & ~relLegal);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      busyMaskQ     <= '0;
      allocValidQ   <= 1'b0;
      allocSlotOHQ  <= '0;
      allocSlotIdxQ <= '0;
      busyCountQ    <= '0;
      fullQ         <= 1'b0;
      relErrQ       <= 1'b0;
    end else begin
      busyMaskQ     <= busyMaskD;
      allocValidQ   <= allocValidD;
      allocSlotOHQ  <= allocSlotOHD;
      allocSlotIdxQ <= allocSlotIdxD;
      busyCountQ    <= busyCountD;
      fullQ         <= fullD;
      relErrQ       <= relErrD;
    end
  end

  assign bus.allocValid   = allocValidQ;
  assign bus.allocSlotOH  = allocSlotOHQ;
  assign bus.allocSlotIdx = allocSlotIdxQ;
  assign bus.busyCount    = busyCountQ;
  assign bus.full         = fullQ;
  assign bus.relErr       = relErrQ;

endmodule

// File: tb/tb_caxi4interconnect_slot_allocator.sv
// Directed bench for the slot allocator with NUM_SLOTS=4.
module tb_caxi4interconnect_slot_allocator;

  logic ACLK;
  logic ARESET;
  int   nCompared;
  int   nMismatched;

  caxi4interconnect_slot_allocator_if #(.NUM_SLOTS(4), .IDX_W(2)) bus ();

  caxi4interconnect_slot_allocator #(
    .NUM_SLOTS (4),
    .IDX_W     (2)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks every visible output at once.
  task automatic checkAll(input string tag, input logic valid, input logic [3:0] oh,
                          input logic [1:0] idx, input logic [2:0] cnt, input logic isFull,
                          input logic err);
    check({tag, ".allocValid"}, 32'(bus.allocValid), 32'(valid));
    check({tag, ".allocSlotOH"}, 32'(bus.allocSlotOH), 32'(oh));
    check({tag, ".allocSlotIdx"}, 32'(bus.allocSlotIdx), 32'(idx));
    check({tag, ".busyCount"}, 32'(bus.busyCount), 32'(cnt));
    check({tag, ".full"}, 32'(bus.full), 32'(isFull));
    check({tag, ".relErr"}, 32'(bus.relErr), 32'(err));
  endtask

  initial begin
    nCompared      = 0;
    nMismatched    = 0;
    ARESET         = 1'b1;
    bus.allocReady = 1'b0;
    bus.relValid   = 1'b0;
    bus.relSlotIdx = 2'd0;
    tick();
    tick();
    checkAll("inReset", 1'b0, 4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);

    // Fill all slots with back-to-back grants.
    ARESET         = 1'b0;
    bus.allocReady = 1'b1;
    tick();
    checkAll("grant0", 1'b1, 4'b0001, 2'd0, 3'd0, 1'b0, 1'b0);
    tick();
    checkAll("grant1", 1'b1, 4'b0010, 2'd1, 3'd1, 1'b0, 1'b0);
    tick();
    checkAll("grant2", 1'b1, 4'b0100, 2'd2, 3'd2, 1'b0, 1'b0);
    tick();
    checkAll("grant3", 1'b1, 4'b1000, 2'd3, 3'd3, 1'b0, 1'b0);
    tick();
    checkAll("filled", 1'b0, 4'b0000, 2'd0, 3'd4, 1'b1, 1'b0);

    // Release slot 2 while full; it is re-offered next edge.
    bus.allocReady = 1'b0;
    bus.relValid   = 1'b1;
    bus.relSlotIdx = 2'd2;
    tick();
    bus.relValid   = 1'b0;
    checkAll("reoffer2", 1'b1, 4'b0100, 2'd2, 3'd3, 1'b0, 1'b0);
    tick();
    checkAll("hold2", 1'b1, 4'b0100, 2'd2, 3'd3, 1'b0, 1'b0);
    bus.allocReady = 1'b1;
    tick();
    bus.allocReady = 1'b0;
    checkAll("take2", 1'b0, 4'b0000, 2'd0, 3'd4, 1'b1, 1'b0);

    // Asynchronous reset while full.
    ARESET = 1'b1;
    #1;
    checkAll("asyncRstFull", 1'b0, 4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);
    tick();
    ARESET = 1'b0;
    tick();
    checkAll("afterRst1", 1'b1, 4'b0001, 2'd0, 3'd0, 1'b0, 1'b0);

    // Release of a free slot flags relErr, which is sticky.
    bus.relValid   = 1'b1;
    bus.relSlotIdx = 2'd3;
    tick();
    bus.relValid   = 1'b0;
    checkAll("relFree", 1'b1, 4'b0001, 2'd0, 3'd0, 1'b0, 1'b1);
    tick();
    checkAll("relErrSticky", 1'b1, 4'b0001, 2'd0, 3'd0, 1'b0, 1'b1);

    ARESET = 1'b1;
    tick();
    check("relErrCleared", 32'(bus.relErr), 32'd0);
    ARESET = 1'b0;
    tick();
    checkAll("afterRst2", 1'b1, 4'b0001, 2'd0, 3'd0, 1'b0, 1'b0);

    // Releasing the offered candidate is illegal; the offer stays.
    bus.relValid   = 1'b1;
    bus.relSlotIdx = 2'd0;
    tick();
    bus.relValid   = 1'b0;
    checkAll("relCand", 1'b1, 4'b0001, 2'd0, 3'd0, 1'b0, 1'b1);

    // Take slots 0..2, leaving 3 offered, then release 1 with a handshake.
    bus.allocReady = 1'b1;
    tick();
    tick();
    tick();
    checkAll("cand3", 1'b1, 4'b1000, 2'd3, 3'd3, 1'b0, 1'b1);
    bus.relValid   = 1'b1;
    bus.relSlotIdx = 2'd1;
    tick();
    bus.relValid   = 1'b0;
    bus.allocReady = 1'b0;
    checkAll("relAndTake", 1'b1, 4'b0010, 2'd1, 3'd3, 1'b0, 1'b1);

    // Reset pulse with three slots outstanding.
    ARESET = 1'b1;
    #1;
    checkAll("asyncRstBusy", 1'b0, 4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);
    tick();
    ARESET = 1'b0;
    tick();
    checkAll("afterRst3", 1'b1, 4'b0001, 2'd0, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
